// File: rtl/if_stage.sv
// Instruction-fetch stage: PC sequencing, delay-slot branches, stall/flush, IF/ID register.
// Optional macro IF_MISALIGN_EXC_EN: flag misaligned fetches instead of forcing word alignment.
module if_stage #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_if,
    input  logic              stall_id,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [INST_W-1:0] rom_inst,
    output logic [ADDR_W-1:0] pc,
    output logic              ce,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic              id_excp
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ce_q;
    logic              pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0] pend_target_q, pend_target_d;
    logic [ADDR_W-1:0] id_pc_q, id_pc_d;
    logic [INST_W-1:0] id_inst_q, id_inst_d;
    logic              id_excp_q, id_excp_d;
    logic              fetch_excp;

    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] a);
`ifdef IF_MISALIGN_EXC_EN
        return a;
`else
        return {a[ADDR_W-1:2], 2'b00};
`endif
    endfunction

`ifdef IF_MISALIGN_EXC_EN
    assign fetch_excp = (pc_q[1:0] != 2'b00);
`else
    assign fetch_excp = 1'b0;
`endif

    // PC and pending-branch next state; a stalled branch is parked until IF can move
    always_comb begin
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        if (!ce_q) begin
            pc_d = RESET_PC;
        end else if (flush) begin
            pc_d         = align_pc(new_pc);
            pend_valid_d = 1'b0;
        end else if (stall_if || stall_id) begin
            if (branch_flag) begin
                pend_valid_d  = 1'b1;
                pend_target_d = branch_target;
            end
        end else if (pend_valid_q) begin
            pc_d         = align_pc(pend_target_q);
            pend_valid_d = 1'b0;
        end else if (branch_flag) begin
            pc_d = align_pc(branch_target);
        end else begin
            pc_d = pc_q + ADDR_W'(4);
        end
    end

    // IF/ID next state; the delay-slot instruction is loaded, never squashed by a branch
    always_comb begin
        id_pc_d   = id_pc_q;
        id_inst_d = id_inst_q;
        id_excp_d = id_excp_q;
        if (flush || (stall_if && !stall_id) || (!stall_id && !ce_q)) begin
            id_pc_d   = '0;
            id_inst_d = '0;
            id_excp_d = 1'b0;
        end else if (!stall_id) begin
            id_pc_d   = pc_q;
            id_inst_d = fetch_excp ? '0 : rom_inst;
            id_excp_d = fetch_excp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ce_q          <= 1'b0;
            pc_q          <= RESET_PC;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
            id_pc_q       <= '0;
            id_inst_q     <= '0;
            id_excp_q     <= 1'b0;
        end else begin
            ce_q          <= 1'b1;
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            id_pc_q       <= id_pc_d;
            id_inst_q     <= id_inst_d;
            id_excp_q     <= id_excp_d;
        end
    end

    assign pc      = pc_q;
    assign ce      = ce_q;
    assign id_pc   = id_pc_q;
    assign id_inst = id_inst_q;
    assign id_excp = id_excp_q;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: expected post-edge state queued per driven cycle, compared after the edge.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst, stall_if, stall_id, flush, branch_flag;
    logic [31:0] new_pc, branch_target, rom_inst;
    logic [31:0] pc, id_pc, id_inst;
    logic        ce, id_excp;

    int n_cmp = 0;
    int n_err = 0;

`ifdef IF_MISALIGN_EXC_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic        ce;
        logic [31:0] id_pc;
        logic [31:0] id_inst;
        logic        id_excp;
    } exp_t;

    exp_t sb[$];

    if_stage dut (
        .clk(clk), .rst(rst), .stall_if(stall_if), .stall_id(stall_id),
        .flush(flush), .new_pc(new_pc), .branch_flag(branch_flag),
        .branch_target(branch_target), .rom_inst(rom_inst),
        .pc(pc), .ce(ce), .id_pc(id_pc), .id_inst(id_inst), .id_excp(id_excp)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (pc)
            32'h0:   rom_inst = 32'h11;
            32'h4:   rom_inst = 32'h22;
            32'h8:   rom_inst = 32'h33;
            32'hC:   rom_inst = 32'h44;
            default: rom_inst = {16'hBEEF, pc[15:0]};
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge state, then compare after the edge.
    task automatic step(input string tag, input logic r, input logic sif, input logic sid,
                        input logic fl, input logic [31:0] npc, input logic br, input logic [31:0] tgt,
                        input logic [31:0] e_pc, input logic e_ce, input logic [31:0] e_idpc,
                        input logic [31:0] e_inst, input logic e_excp);
        exp_t e;
        rst = r; stall_if = sif; stall_id = sid; flush = fl;
        new_pc = npc; branch_flag = br; branch_target = tgt;
        e.pc = e_pc; e.ce = e_ce; e.id_pc = e_idpc; e.id_inst = e_inst; e.id_excp = e_excp;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, ".pc"}, pc, e.pc);
        check({tag, ".ce"}, {31'd0, ce}, {31'd0, e.ce});
        check({tag, ".id_pc"}, id_pc, e.id_pc);
        check({tag, ".id_inst"}, id_inst, e.id_inst);
        check({tag, ".id_excp"}, {31'd0, id_excp}, {31'd0, e.id_excp});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stall_if = 1'b0; stall_id = 1'b0; flush = 1'b0;
        new_pc = '0; branch_flag = 1'b0; branch_target = '0;
        #1;
        //    tag      rst sif sid fl new_pc       br tgt      pc            ce idpc          inst           excp
        step("rst0",   1, 0, 0, 0, 32'h0,       0, 32'h0,  32'h0,        0, 32'h0,        32'h0,         0);
        step("rst1",   1, 0, 0, 0, 32'h0,       0, 32'h0,  32'h0,        0, 32'h0,        32'h0,         0);
        step("ceup",   0, 0, 0, 0, 32'h0,       0, 32'h0,  32'h0,        1, 32'h0,        32'h0,         0);
        step("seq1",   0, 0, 0, 0, 32'h0,       0, 32'h0,  32'h4,        1, 32'h0,        32'h11,        0);
        step("seq2",   0, 0, 0, 0, 32'h0,       0, 32'h0,  32'h8,        1, 32'h4,        32'h22,        0);
        step("seq3",   0, 0, 0, 0, 32'h0,       0, 32'h0,  32'hC,        1, 32'h8,        32'h33,        0);
        step("seq4",   0, 0, 0, 0, 32'h0,       0, 32'h0,  32'h10,       1, 32'hC,        32'h44,        0);
        // Reach pc=8 again through a flush, then branch with a delay slot
        step("fl8",    0, 0, 0, 1, 32'h8,       0, 32'h0,  32'h8,        1, 32'h0,        32'h0,         0);
        step("brds",   0, 0, 0, 0, 32'h0,       1, 32'h40, 32'h40,       1, 32'h8,        32'h33,        0);
        step("br44",   0, 0, 0, 0, 32'h0,       0, 32'h0,  32'h44,       1, 32'h40,       32'hBEEF0040,  0);
        step("stl1",   0, 1, 0, 0, 32'h0,       1, 32'h80, 32'h44,       1, 32'h0,        32'h0,         0);
        step("stl2",   0, 1, 0, 0, 32'h0,       0, 32'h0,  32'h44,       1, 32'h0,        32'h0,         0);
        step("pend",   0, 0, 0, 0, 32'h0,       0, 32'h0,  32'h80,       1, 32'h44,       32'hBEEF0044,  0);
        step("pclr",   0, 0, 0, 0, 32'h0,       0, 32'h0,  32'h84,       1, 32'h80,       32'hBEEF0080,  0);
        step("flbr",   0, 1, 0, 1, 32'h20,      1, 32'h100,32'h20,       1, 32'h0,        32'h0,         0);
        step("flnop",  0, 0, 0, 0, 32'h0,       0, 32'h0,  32'h24,       1, 32'h20,       32'hBEEF0020,  0);
        step("flwrap", 0, 0, 0, 1, 32'hFFFFFFFC,0, 32'h0,  32'hFFFFFFFC, 1, 32'h0,        32'h0,         0);
        step("wrap",   0, 0, 0, 0, 32'h0,       0, 32'h0,  32'h0,        1, 32'hFFFFFFFC, 32'hBEEFFFFC,  0);
        step("wrap1",  0, 0, 0, 0, 32'h0,       0, 32'h0,  32'h4,        1, 32'h0,        32'h11,        0);
        step("hold",   0, 1, 1, 0, 32'h0,       0, 32'h0,  32'h4,        1, 32'h0,        32'h11,        0);
        step("unhold", 0, 0, 0, 0, 32'h0,       0, 32'h0,  32'h8,        1, 32'h4,        32'h22,        0);
        step("mis0",   0, 0, 0, 0, 32'h0,       1, 32'h42, MIS ? 32'h42 : 32'h40, 1, 32'h8, 32'h33,   0);
        step("mis1",   0, 0, 0, 0, 32'h0,       0, 32'h0,  MIS ? 32'h46 : 32'h44, 1,
             MIS ? 32'h42 : 32'h40, MIS ? 32'h0 : 32'hBEEF0040, MIS);
        // A branch parked during a stall must not survive a reset
        step("rpend",  0, 1, 0, 0, 32'h0,       1, 32'h80, MIS ? 32'h46 : 32'h44, 1, 32'h0, 32'h0,     0);
        step("rmid",   1, 0, 0, 0, 32'h0,       0, 32'h0,  32'h0,        0, 32'h0,        32'h0,         0);
        step("rce",    0, 0, 0, 0, 32'h0,       0, 32'h0,  32'h0,        1, 32'h0,        32'h0,         0);
        step("rnopnd", 0, 0, 0, 0, 32'h0,       0, 32'h0,  32'h4,        1, 32'h0,        32'h11,        0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
